// File: rtl/jtag_tap_seq.sv
// jtag_tap_seq: turns IR/DR scan commands into a legal IEEE 1149.1 TMS/TDI stream and
// returns the captured TDO bits. Define JTAG_SEQ_IDLE_CNT_EN for a Run-Test/Idle dwell port.
module jtag_tap_seq #(
  parameter int unsigned MAX_BITS = 32,
  parameter int unsigned LEN_W    = 6
) (
  input  logic                TCLK,
  input  logic                TRST,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_ir,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [MAX_BITS-1:0] cmd_data,
  output logic                TMS,
  output logic                TDI,
  input  logic                TDO,
  output logic                rsp_valid,
  output logic                rsp_err,
  output logic [MAX_BITS-1:0] rsp_data,
  output logic                busy
`ifdef JTAG_SEQ_IDLE_CNT_EN
  ,
  input  logic [7:0]          idle_cnt
`endif
);

  localparam logic [LEN_W-1:0] MaxLen   = LEN_W'(MAX_BITS);
  localparam logic [LEN_W-1:0] LenOne   = LEN_W'(1);
  localparam logic [2:0]       InitLast = 3'd4;

  typedef enum logic [3:0] {
    StInit,
    StGoIdle,
    StReady,
    StSelDr,
    StSelIr,
    StCapture,
    StShift,
    StUpdate,
    StRunIdle,
    StResp
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          init_cnt_q, init_cnt_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                ir_q, ir_d;
  logic [MAX_BITS-1:0] sr_q, sr_d;
  logic [MAX_BITS-1:0] cap_q, cap_d;
  logic [MAX_BITS-1:0] bit_q, bit_d;
  logic [MAX_BITS-1:0] rsp_data_q;
  logic                err_q, err_d;
  logic                tms_q, tms_d;
  logic                tdi_q, tdi_d;
  logic                len_bad;

`ifdef JTAG_SEQ_IDLE_CNT_EN
  logic [7:0]          dwell_q, dwell_d;
`endif

  assign len_bad = (cmd_len == '0) || (cmd_len > MaxLen);

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    cnt_d      = cnt_q;
    ir_d       = ir_q;
    sr_d       = sr_q;
    cap_d      = cap_q;
    bit_d      = bit_q;
    err_d      = err_q;
`ifdef JTAG_SEQ_IDLE_CNT_EN
    dwell_d    = dwell_q;
`endif
    unique case (state_q)
      StInit: begin
        if (init_cnt_q == InitLast) begin
          state_d = StGoIdle;
        end else begin
          init_cnt_d = init_cnt_q + 3'd1;
        end
      end
      StGoIdle: state_d = StReady;
      StReady: begin
        if (cmd_valid) begin
          ir_d  = cmd_ir;
          cnt_d = cmd_len;
          sr_d  = cmd_data;
          cap_d = '0;
          // One-hot pointer to the capture bit for the current shift cycle.
          bit_d = {{(MAX_BITS-1){1'b0}}, 1'b1};
`ifdef JTAG_SEQ_IDLE_CNT_EN
          dwell_d = idle_cnt;
`endif
          if (len_bad) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            err_d   = 1'b0;
            state_d = StSelDr;
          end
        end
      end
      StSelDr:   state_d = ir_q ? StSelIr : StCapture;
      StSelIr:   state_d = StCapture;
      StCapture: state_d = StShift;
      StShift: begin
        sr_d  = sr_q >> 1;
        bit_d = bit_q << 1;
        if (TDO) begin
          cap_d = cap_q | bit_q;
        end
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LenOne;
        end
        if (cnt_q <= LenOne) begin
          state_d = StUpdate;
        end
      end
      StUpdate: state_d = StRunIdle;
      StRunIdle: begin
`ifdef JTAG_SEQ_IDLE_CNT_EN
        if (dwell_q == 8'd0) begin
          state_d = StResp;
        end else begin
          dwell_d = dwell_q - 8'd1;
        end
`else
        state_d = StResp;
`endif
      end
      StResp:  state_d = StReady;
      default: state_d = StInit;
    endcase
  end

  // Pins are registered from the next state so they line up with the state they encode.
  always_comb begin
    tms_d = 1'b0;
    tdi_d = 1'b0;
    unique case (state_d)
      StInit, StSelDr, StSelIr, StUpdate: tms_d = 1'b1;
      StShift: begin
        tms_d = (cnt_d == LenOne);
        tdi_d = sr_d[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge TCLK or posedge TRST) begin
    if (TRST) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      cnt_q      <= '0;
      ir_q       <= 1'b0;
      sr_q       <= '0;
      cap_q      <= '0;
      bit_q      <= '0;
      err_q      <= 1'b0;
      tms_q      <= 1'b1;
      tdi_q      <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      cnt_q      <= cnt_d;
      ir_q       <= ir_d;
      sr_q       <= sr_d;
      cap_q      <= cap_d;
      bit_q      <= bit_d;
      err_q      <= err_d;
      tms_q      <= tms_d;
      tdi_q      <= tdi_d;
      if (state_d == StResp) begin
        rsp_data_q <= cap_d;
      end
    end
  end

`ifdef JTAG_SEQ_IDLE_CNT_EN
  always_ff @(posedge TCLK or posedge TRST) begin
    if (TRST) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_d;
    end
  end
`endif

  assign TMS       = tms_q;
  assign TDI       = tdi_q;
  assign cmd_ready = (state_q == StReady);
  assign busy      = ~cmd_ready;
  assign rsp_valid = (state_q == StResp);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_jtag_tap_seq.sv
// Bench for jtag_tap_seq: per-command TMS/TDI/response expectations plus a shadow IEEE 1149.1 TAP.
module tb_jtag_tap_seq;

  localparam int MB = 32;
  localparam int LW = 6;

  logic          TCLK = 1'b0;
  logic          TRST = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ir = 1'b0;
  logic [LW-1:0] cmd_len = '0;
  logic [MB-1:0] cmd_data = '0;
  logic          cmd_ready, TMS, TDI, TDO, rsp_valid, rsp_err, busy;
  logic [MB-1:0] rsp_data;
  logic          tdo_loop = 1'b1;
  logic          tdo_rand = 1'b0;

  int tests  = 0;
  int failed = 0;

  assign TDO = tdo_loop ? TDI : tdo_rand;

  always #5 TCLK = ~TCLK;

  jtag_tap_seq #(.MAX_BITS(MB), .LEN_W(LW)) dut (
    .TCLK      (TCLK),
    .TRST      (TRST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ir    (cmd_ir),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .TMS       (TMS),
    .TDI       (TDI),
    .TDO       (TDO),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  typedef enum int {
    TlR, Rti, SelDr, CapDr, ShDr, Ex1Dr, PaDr, Ex2Dr, UpDr,
    SelIr, CapIr, ShIr, Ex1Ir, PaIr, Ex2Ir, UpIr
  } tap_e;

  // Shadow TAP starts somewhere arbitrary; the INIT sequence must recover it.
  tap_e tap = ShDr;

  function automatic tap_e tap_step(input tap_e s, input logic tms);
    bit m;
    m = (tms === 1'b1);
    case (s)
      TlR:     return m ? TlR   : Rti;
      Rti:     return m ? SelDr : Rti;
      SelDr:   return m ? SelIr : CapDr;
      CapDr:   return m ? Ex1Dr : ShDr;
      ShDr:    return m ? Ex1Dr : ShDr;
      Ex1Dr:   return m ? UpDr  : PaDr;
      PaDr:    return m ? Ex2Dr : PaDr;
      Ex2Dr:   return m ? UpDr  : ShDr;
      UpDr:    return m ? SelDr : Rti;
      SelIr:   return m ? TlR   : CapIr;
      CapIr:   return m ? Ex1Ir : ShIr;
      ShIr:    return m ? Ex1Ir : ShIr;
      Ex1Ir:   return m ? UpIr  : PaIr;
      PaIr:    return m ? Ex2Ir : PaIr;
      Ex2Ir:   return m ? UpIr  : ShIr;
      UpIr:    return m ? SelDr : Rti;
      default: return TlR;
    endcase
  endfunction

  always @(posedge TCLK) tap <= tap_step(tap, TMS);

  task automatic tick();
    @(posedge TCLK);
    #1;
  endtask

  // Called 1 time unit after a rising edge with TRST high; cycle 1 is the one now running.
  task automatic release_and_check(input string tag);
    bit exp_tms, exp_rdy;
    TRST = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      exp_tms = (c <= 5);
      exp_rdy = (c == 7);
      tests++;
      if ({TMS, TDI, cmd_ready, busy, rsp_valid} !== {exp_tms, 1'b0, exp_rdy, ~exp_rdy, 1'b0}) begin
        failed++;
        $display("FAIL %s_init_c%0d got tms/tdi/rdy/busy/rv=%b want %b", tag, c,
                 {TMS, TDI, cmd_ready, busy, rsp_valid},
                 {exp_tms, 1'b0, exp_rdy, ~exp_rdy, 1'b0});
      end
      if (c < 7) tick();
    end
    tests++;
    if (tap !== Rti) begin
      failed++;
      $display("FAIL %s_tap_after_init got %s want Rti", tag, tap.name());
    end
  endtask

  // tdo_mode: 0 = TDO looped from TDI, 1 = random TDO per cycle, 2 = TDO tied high.
  // Returns in the READY cycle following the response.
  task automatic do_cmd(input bit ir, input int len, input logic [MB-1:0] data,
                        input int tdo_mode, input bit keep_valid, output int waited);
    int            pre, last;
    bit            legal, exp_tms, exp_tdi;
    logic [MB-1:0] exp_rsp;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 64) begin
      tick();
      waited++;
    end
    tests++;
    if (cmd_ready !== 1'b1) begin
      failed++;
      $display("FAIL cmd_ready_timeout got %b want 1", cmd_ready);
      return;
    end
    tests++;
    if (tap !== Rti) begin
      failed++;
      $display("FAIL tap_idle_at_ready got %s want Rti", tap.name());
    end
    cmd_valid = 1'b1;
    cmd_ir    = ir;
    cmd_len   = LW'(len);
    cmd_data  = data;
    tdo_loop  = (tdo_mode == 0);
    tdo_rand  = (tdo_mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
    tick();
    if (!keep_valid) cmd_valid = 1'b0;
    legal = (len >= 1) && (len <= MB);
    if (!legal) begin
      tests++;
      if ({rsp_valid, rsp_err, TMS, TDI} !== 4'b1100) begin
        failed++;
        $display("FAIL illegal_len%0d_resp got rv/err/tms/tdi=%b want 1100", len,
                 {rsp_valid, rsp_err, TMS, TDI});
      end
      tick();
      tests++;
      if ({rsp_valid, cmd_ready, TMS} !== 3'b010) begin
        failed++;
        $display("FAIL illegal_len%0d_after got rv/rdy/tms=%b want 010", len,
                 {rsp_valid, cmd_ready, TMS});
      end
      return;
    end
    pre     = ir ? 3 : 2;
    last    = pre + len + 2;
    exp_rsp = '0;
    for (int c = 1; c <= last; c++) begin
      if (tdo_mode == 1) tdo_rand = 1'($urandom_range(0, 1));
      exp_tms = (c == 1) || (ir && c == 2) || (c >= pre + len && c <= pre + len + 1);
      exp_tdi = (c > pre && c <= pre + len) ? data[c-pre-1] : 1'b0;
      if (c > pre && c <= pre + len) exp_rsp[c-pre-1] = (tdo_mode == 0) ? exp_tdi : tdo_rand;
      tests++;
      if ({TMS, TDI, rsp_valid, cmd_ready} !== {exp_tms, exp_tdi, 2'b00}) begin
        failed++;
        $display("FAIL scan_ir%0d_len%0d_c%0d got tms/tdi/rv/rdy=%b want %b", ir, len, c,
                 {TMS, TDI, rsp_valid, cmd_ready}, {exp_tms, exp_tdi, 2'b00});
      end
      tick();
    end
    tests++;
    if ({rsp_valid, rsp_err} !== 2'b10 || rsp_data !== exp_rsp) begin
      failed++;
      $display("FAIL resp_ir%0d_len%0d got rv/err=%b data=%h want 10 data=%h", ir, len,
               {rsp_valid, rsp_err}, rsp_data, exp_rsp);
    end
    tests++;
    if (tap !== Rti) begin
      failed++;
      $display("FAIL tap_idle_at_resp got %s want Rti", tap.name());
    end
    tick();
    tests++;
    if ({rsp_valid, cmd_ready, busy, TMS} !== 4'b0100 || rsp_data !== exp_rsp) begin
      failed++;
      $display("FAIL post_resp got rv/rdy/busy/tms=%b data=%h want 0100 data=%h",
               {rsp_valid, cmd_ready, busy, TMS}, rsp_data, exp_rsp);
    end
  endtask

  task automatic test_reset();
    TRST = 1'b1;
    #2;
    tests++;
    if ({TMS, TDI, cmd_ready, rsp_valid, rsp_err, busy} !== 6'b100001 || rsp_data !== '0) begin
      failed++;
      $display("FAIL reset_values got tms/tdi/rdy/rv/err/busy=%b data=%h want 100001 data=0",
               {TMS, TDI, cmd_ready, rsp_valid, rsp_err, busy}, rsp_data);
    end
    tick();
    tick();
    release_and_check("reset");
  endtask

  task automatic test_dr_loop();
    int w;
    do_cmd(1'b0, 8, 32'h0000_00A5, 0, 1'b0, w);
  endtask

  task automatic test_ir_ones();
    int w;
    do_cmd(1'b1, 4, 32'h0000_0003, 2, 1'b0, w);
  endtask

  task automatic test_illegal_len();
    int w;
    do_cmd(1'b0, 0, 32'hFFFF_FFFF, 0, 1'b0, w);
    do_cmd(1'b1, 33, 32'h1234_5678, 0, 1'b0, w);
    do_cmd(1'b0, 63, 32'h0F0F_0F0F, 1, 1'b0, w);
  endtask

  task automatic test_back_to_back();
    int w1, w2;
    do_cmd(1'b0, 1, $urandom, 1, 1'b1, w1);
    do_cmd(1'b0, 1, $urandom, 1, 1'b0, w2);
    tests++;
    if (w2 !== 0) begin
      failed++;
      $display("FAIL back_to_back_gap got %0d wait cycles want 0", w2);
    end
  endtask

  task automatic test_random();
    int w, len;
    bit ir;
    for (int i = 0; i < 24; i++) begin
      ir  = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(33, 63))
                                        : $urandom_range(1, MB);
      do_cmd(ir, len, $urandom, $urandom_range(0, 2), 1'($urandom_range(0, 1)), w);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    int            w;
    logic [MB-1:0] data;
    data = $urandom;
    w    = 0;
    while (cmd_ready !== 1'b1 && w < 64) begin
      tick();
      w++;
    end
    cmd_valid = 1'b1;
    cmd_ir    = 1'b0;
    cmd_len   = LW'(16);
    cmd_data  = data;
    tdo_loop  = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (7) tick();
    tests++;
    if ({TMS, TDI} !== {1'b0, data[5]}) begin
      failed++;
      $display("FAIL midscan_bit5 got tms/tdi=%b want %b", {TMS, TDI}, {1'b0, data[5]});
    end
    TRST = 1'b1;
    #1;
    tests++;
    if ({TMS, TDI, rsp_valid, rsp_err, cmd_ready, busy} !== 6'b100001) begin
      failed++;
      $display("FAIL midscan_reset got tms/tdi/rv/err/rdy/busy=%b want 100001",
               {TMS, TDI, rsp_valid, rsp_err, cmd_ready, busy});
    end
    tick();
    tick();
    release_and_check("midscan");
    do_cmd(1'b0, 20, $urandom, 1, 1'b0, w);
  endtask

  initial begin
    test_reset();
    test_dr_loop();
    test_ir_ones();
    test_illegal_len();
    test_back_to_back();
    test_random();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
